// File: rtl/rotary_emulator.sv
// Quadrature encoder emulator: turns queued step requests into A/B detent sequences.
// Pending requests net out in a saturating signed counter; one detent is emitted per unit.
module rotary_emulator #(
  parameter int unsigned PHASE_CYCLES = 16,
  parameter int unsigned PEND_MAX     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_inc,
  input  logic       step_dec,
  output logic       rotary_inc_a,
  output logic       rotary_inc_b,
  output logic       busy,
  output logic [7:0] pending
);

  typedef enum logic [2:0] {StIdle, StPh1, StPh2, StPh3, StGap} state_e;

  localparam logic [7:0]        PhaseLast = 8'(PHASE_CYCLES - 1);
  localparam logic signed [9:0] PendMax   = 10'(PEND_MAX);

  state_e            r_state;
  logic [7:0]        r_timer;
  logic              r_dir;  // 1 = dec
  logic              r_a;
  logic              r_b;
  logic signed [7:0] r_pending;

  logic              w_phase_done;
  logic              w_commit;
  logic signed [9:0] w_delta;
  logic signed [9:0] w_sum;
  logic signed [7:0] w_pending_d;

  assign w_phase_done = (r_timer == PhaseLast);
  assign w_commit     = (r_state == StIdle) && (r_pending != 8'sd0);

  always_comb begin
    w_delta = 10'sd0;
    if (w_commit) begin
      w_delta = r_pending[7] ? -10'sd1 : 10'sd1;
    end
    w_sum = {{2{r_pending[7]}}, r_pending};
    w_sum = w_sum + (step_inc ? 10'sd1 : 10'sd0) - (step_dec ? 10'sd1 : 10'sd0) - w_delta;
    if (w_sum > PendMax) begin
      w_pending_d = PendMax[7:0];
    end else if (w_sum < -PendMax) begin
      w_pending_d = 8'(-PendMax);
    end else begin
      w_pending_d = w_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 8'sd0;
    end else begin
      r_pending <= w_pending_d;
    end
  end

  // Outputs are registered alongside the state so each encoding appears on the entry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_timer <= 8'd0;
      r_dir   <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_timer <= 8'd0;
          if (w_commit) begin
            r_state      <= StPh1;
            r_dir        <= r_pending[7];
            {r_a, r_b}   <= r_pending[7] ? 2'b10 : 2'b01;
          end
        end
        StPh1: begin
          if (w_phase_done) begin
            r_state    <= StPh2;
            r_timer    <= 8'd0;
            {r_a, r_b} <= 2'b11;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        StPh2: begin
          if (w_phase_done) begin
            r_state    <= StPh3;
            r_timer    <= 8'd0;
            {r_a, r_b} <= r_dir ? 2'b01 : 2'b10;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        StPh3: begin
          if (w_phase_done) begin
            r_state    <= StGap;
            r_timer    <= 8'd0;
            {r_a, r_b} <= 2'b00;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        StGap: begin
          if (w_phase_done) begin
            r_state <= StIdle;
            r_timer <= 8'd0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: begin
          r_state    <= StIdle;
          r_timer    <= 8'd0;
          {r_a, r_b} <= 2'b00;
        end
      endcase
    end
  end

  assign rotary_inc_a = r_a;
  assign rotary_inc_b = r_b;
  assign busy         = (r_state != StIdle);
  assign pending      = r_pending;

endmodule

// File: tb/tb_rotary_emulator.sv
// Bench for rotary_emulator: spec vector tables, corner-case sequences and random traffic
// compared against a detent-position reference model.
module tb_rotary_emulator;

  localparam int P    = 4;
  localparam int PMAX = 15;

  logic       clk;
  logic       rst_n;
  logic       step_inc;
  logic       step_dec;
  logic       rotary_inc_a;
  logic       rotary_inc_b;
  logic       busy;
  logic [7:0] pending;

  rotary_emulator #(.PHASE_CYCLES(P), .PEND_MAX(PMAX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .step_inc     (step_inc),
    .step_dec     (step_dec),
    .rotary_inc_a (rotary_inc_a),
    .rotary_inc_b (rotary_inc_b),
    .busy         (busy),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       inc;
    logic       dec;
    logic [1:0] ab;
    logic       bsy;
    int         pend;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: a detent is a position t in [0, 4P) within a fixed 4-entry pattern.
  logic [1:0] pat_inc [4];
  logic [1:0] pat_dec [4];
  int   m_pend;
  bit   m_active;
  int   m_t;
  bit   m_dir;
  int   m_det;
  int   m_det_dec;

  logic [1:0] s_ab;
  logic       s_busy;
  int         s_pend;
  logic [1:0] prev_ab;
  logic       prev_busy;
  int         d_det;
  int         d_det_dec;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend   = 0;
    m_active = 0;
    m_t      = 0;
    prev_ab  = 2'b00;
    prev_busy = 1'b0;
  endtask

  function automatic logic [1:0] model_ab();
    if (!m_active) return 2'b00;
    return m_dir ? pat_dec[m_t / P] : pat_inc[m_t / P];
  endfunction

  // One clock: drive inputs, advance model on the edge, sample and compare on the falling edge.
  task automatic tick(input logic inc, input logic dec);
    int delta;
    int s;
    step_inc = inc;
    step_dec = dec;
    @(posedge clk);
    delta = (!m_active && m_pend != 0) ? (m_pend > 0 ? 1 : -1) : 0;
    s = m_pend + int'(inc) - int'(dec) - delta;
    if (s > PMAX) s = PMAX;
    if (s < -PMAX) s = -PMAX;
    if (m_active) begin
      m_t++;
      if (m_t == 4 * P) m_active = 0;
    end else if (delta != 0) begin
      m_active = 1;
      m_t      = 0;
      m_dir    = (delta < 0);
      m_det++;
      if (delta < 0) m_det_dec++;
    end
    m_pend = s;
    @(negedge clk);
    s_ab   = {rotary_inc_a, rotary_inc_b};
    s_busy = busy;
    s_pend = int'($signed(pending));
    chk("model_ab", int'(s_ab), int'(model_ab()));
    chk("model_busy", int'(s_busy), int'(m_active));
    chk("model_pending", s_pend, m_pend);
    chk("one_bit_change", int'($countones(s_ab ^ prev_ab) <= 1), 1);
    if (s_busy && !prev_busy) begin
      d_det++;
      if (s_ab == 2'b10) d_det_dec++;
    end
    prev_ab   = s_ab;
    prev_busy = s_busy;
    step_inc  = 1'b0;
    step_dec  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || pending != 8'd0) && n < budget) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("idle_within_budget", int'(n < budget), 1);
    tick(1'b0, 1'b0);
  endtask

  vec_t vinc [18];
  vec_t vdec [18];

  initial begin
    int det0;
    int dec0;
    pat_inc = '{2'b01, 2'b11, 2'b10, 2'b00};
    pat_dec = '{2'b10, 2'b11, 2'b01, 2'b00};
    vinc[0] = '{1'b1, 1'b0, 2'b00, 1'b0, 1};
    vdec[0] = '{1'b0, 1'b1, 2'b00, 1'b0, -1};
    for (int i = 1; i <= 16; i++) begin
      vinc[i] = '{1'b0, 1'b0, pat_inc[(i - 1) / 4], 1'b1, 0};
      vdec[i] = '{1'b0, 1'b0, pat_dec[(i - 1) / 4], 1'b1, 0};
    end
    vinc[17] = '{1'b0, 1'b0, 2'b00, 1'b0, 0};
    vdec[17] = '{1'b0, 1'b0, 2'b00, 1'b0, 0};

    m_det = 0; m_det_dec = 0; d_det = 0; d_det_dec = 0;
    step_inc = 1'b0;
    step_dec = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_ab", int'({rotary_inc_a, rotary_inc_b}), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pending", int'(pending), 0);
    rst_n = 1'b1;

    // Single inc detent, then single dec detent, edge by edge.
    for (int i = 0; i < 18; i++) begin
      tick(vinc[i].inc, vinc[i].dec);
      chk("vec_inc_ab", int'(s_ab), int'(vinc[i].ab));
      chk("vec_inc_busy", int'(s_busy), int'(vinc[i].bsy));
      chk("vec_inc_pending", s_pend, vinc[i].pend);
    end
    for (int i = 0; i < 18; i++) begin
      tick(vdec[i].inc, vdec[i].dec);
      chk("vec_dec_ab", int'(s_ab), int'(vdec[i].ab));
      chk("vec_dec_busy", int'(s_busy), int'(vdec[i].bsy));
      chk("vec_dec_pending", s_pend, vdec[i].pend);
    end

    // 20 inc pulses: pending must clamp at +PMAX, and every queued unit is emitted.
    det0 = d_det;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    chk("sat_pending", s_pend, PMAX);
    tick(1'b1, 1'b0);
    chk("sat_hold", s_pend, PMAX);
    tick(1'b0, 1'b1);
    chk("sat_opposite_accepted", s_pend, PMAX - 1);
    wait_idle(2000);
    chk("sat_drained", s_pend, 0);
    chk("sat_detents", d_det - det0, m_det - det0);

    // Simultaneous inc/dec while idle is a no-op.
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1);
      chk("both_pending", s_pend, 0);
      chk("both_busy", int'(s_busy), 0);
      chk("both_ab", int'(s_ab), 0);
    end

    // Requests during an in-flight detent only touch pending.
    det0 = d_det;
    dec0 = d_det_dec;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("inflight_pending2", s_pend, 2);
    tick(1'b0, 1'b1);
    chk("inflight_pending1", s_pend, 1);
    chk("inflight_ab_unchanged", int'(s_ab), 1);
    wait_idle(500);
    chk("inflight_detents", d_det - det0, 2);
    chk("inflight_no_dec", d_det_dec - dec0, 0);

    // Reset during PH2 clears outputs without a clock edge.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    for (int n = 0; n < 50 && s_ab != 2'b11; n++) tick(1'b0, 1'b0);
    chk("reached_ph2", int'(s_ab), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ab", int'({rotary_inc_a, rotary_inc_b}), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_pending", int'(pending), 0);
    #1 rst_n = 1'b1;
    model_reset();
    tick(1'b0, 1'b1);
    chk("post_reset_accept", s_pend, -1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      tick(r < 4 || r == 9, (r >= 4 && r < 7) || r == 9);
    end
    wait_idle(3000);
    chk("rand_detents", d_det, m_det);
    chk("rand_dec_detents", d_det_dec, m_det_dec);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
